dpd_coef_ctrl: RTL

Double-buffered coefficient controller for the 15-tap memory-polynomial DPD datapath (5 magnitude orders x 3 delays).
- Host/adaptation engine writes complex coefficients into a shadow bank, then commits them.
- The controller swaps the shadow bank to active only on a datapath sync strobe, so the DPD never sees a half-updated coefficient set.
- Active bank outputs drive the DPD coeff interface directly.

---
 rtl/dpd_coef_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dpd_coef_ctrl.sv
// dpd_coef_ctrl: double-buffered coefficient bank controller for the 15-tap memory-polynomial DPD
//   clk, reset_b                  clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_i/wr_q  shadow-bank write handshake
//   commit, abort, swap_strobe    load control and datapath sync point
//   coef_i, coef_q                active bank, index k at [k*W +: W]
//   bank_sel, swap_done, err_incomplete, err_addr, swap_cnt, state  status
//   DPD_COEF_READBACK_EN adds rd_en/rd_addr/rd_bank and rd_i/rd_q/rd_valid
module dpd_coef_ctrl #(
  parameter int N_COEF = 15,
  parameter int W = 20,
  parameter int UNITY_IDX = 0,
  parameter int UNITY_VAL = 262144
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [3:0]          wr_addr,
  input  logic [W-1:0]        wr_i,
  input  logic [W-1:0]        wr_q,
  input  logic                commit,
  input  logic                abort,
  input  logic                swap_strobe,
  output logic [N_COEF*W-1:0] coef_i,
  output logic [N_COEF*W-1:0] coef_q,
  output logic                bank_sel,
  output logic                swap_done,
  output logic                err_incomplete,
  output logic                err_addr,
  output logic [7:0]          swap_cnt,
  output logic [1:0]          state
`ifdef DPD_COEF_READBACK_EN
  ,
  input  logic                rd_en,
  input  logic [3:0]          rd_addr,
  input  logic                rd_bank,
  output logic [W-1:0]        rd_i,
  output logic [W-1:0]        rd_q,
  output logic                rd_valid
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, PEND, SWAP} state_t;
  localparam logic [W-1:0] UNITY_I = W'(UNITY_VAL);
  localparam logic [N_COEF*W-1:0] COEF_RST = {{(N_COEF*W-W){1'b0}}, UNITY_I} << (UNITY_IDX*W);
  state_t st, nxt;
  logic [W-1:0] bi [2][N_COEF];
  logic [W-1:0] bq [2][N_COEF];
  logic [N_COEF-1:0] mask, mask_w, mask_n;
  logic acc, in_rng, wr_ok, wr_bad, loading, full, abort_eff, rej, sh;
  assign state = st;
  assign sh = ~bank_sel;
  always_comb begin
    acc = wr_valid & wr_ready;
    in_rng = {28'd0, wr_addr} < N_COEF;
    wr_ok = acc & in_rng;
    wr_bad = acc & ~in_rng;
    mask_w = wr_ok ? mask | (N_COEF'(1) << wr_addr) : mask;
    full = &mask_w;
    // a write in IDLE moves to LOAD in the same cycle, so a coincident commit is judged as a LOAD commit
    loading = (st == LOAD) | (st == IDLE & acc);
    abort_eff = abort & (st == LOAD | st == PEND);
    nxt = st == SWAP ? IDLE :
          abort_eff ? IDLE :
          st == PEND ? (swap_strobe ? SWAP : PEND) :
          loading ? (commit & full ? PEND : LOAD) : IDLE;
    rej = commit & (st == IDLE | st == LOAD) & ~abort_eff & ~(loading & full);
    mask_n = (st == SWAP | abort_eff) ? '0 : mask_w;
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      st <= IDLE;
      bank_sel <= 1'b0;
      mask <= '0;
      wr_ready <= 1'b0;
      swap_done <= 1'b0;
      err_incomplete <= 1'b0;
      err_addr <= 1'b0;
      swap_cnt <= '0;
      for (int k = 0; k < N_COEF; k++) begin
        bi[0][k] <= '0;
        bi[1][k] <= '0;
        bq[0][k] <= '0;
        bq[1][k] <= '0;
      end
      bi[0][UNITY_IDX] <= UNITY_I;
      coef_i <= COEF_RST;
      coef_q <= '0;
    end else begin
      if (wr_ok) begin
        bi[sh][wr_addr] <= wr_i;
        bq[sh][wr_addr] <= wr_q;
      end
      if (wr_bad) err_addr <= 1'b1;
      st <= nxt;
      mask <= mask_n;
      wr_ready <= nxt == IDLE || nxt == LOAD;
      err_incomplete <= rej;
      swap_done <= st == SWAP;
      if (st == SWAP) begin
        bank_sel <= sh;
        swap_cnt <= swap_cnt + 8'd1;
        for (int k = 0; k < N_COEF; k++) begin
          coef_i[k*W +: W] <= bi[sh][k];
          coef_q[k*W +: W] <= bq[sh][k];
        end
      end
    end
`ifdef DPD_COEF_READBACK_EN
  logic rd_rng, rd_sel;
  assign rd_rng = {28'd0, rd_addr} < N_COEF;
  assign rd_sel = bank_sel ^ rd_bank;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      rd_valid <= 1'b0;
      rd_i <= '0;
      rd_q <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_i <= rd_rng ? bi[rd_sel][rd_addr] : '0;
        rd_q <= rd_rng ? bq[rd_sel][rd_addr] : '0;
      end
    end
`endif
endmodule
